// File: rtl/scmi_channel_scheduler_pkg.sv
// scmi_sched_pkg: state encoding and default sizing shared by the SCMI channel scheduler
package scmi_sched_pkg;
    localparam int DefNumAgents     = 4;
    localparam int DefTimeoutCycles = 1024;
    typedef enum logic [2:0] {IDLE, GRANT, DOORBELL, WAIT_CMPL, NOTIFY} sched_state_e;
endpackage

// File: rtl/scmi_channel_scheduler_rr_picker.sv
// scmi_rr_picker: combinational round-robin pick, searching upward from ptr_i with wrap-around
module scmi_rr_picker
    import scmi_sched_pkg::*;
#(
    parameter int NumAgents = DefNumAgents,
    localparam int IW = $clog2(NumAgents)
) (
    input  logic [NumAgents-1:0] req_i,
    input  logic [IW-1:0]        ptr_i,
    output logic [NumAgents-1:0] gnt_o,
    output logic                 valid_o
);
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NumAgents; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            idx = IW'(sum >= (IW+1)'(NumAgents) ? sum - (IW+1)'(NumAgents) : sum);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/scmi_channel_scheduler.sv
// scmi_channel_scheduler: arbitrates one SCMI mailbox channel among agents via doorbell/completion handshake
module scmi_channel_scheduler
    import scmi_sched_pkg::*;
#(
    parameter int NumAgents     = DefNumAgents,
    parameter int TimeoutCycles = DefTimeoutCycles
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumAgents-1:0] req_i,
    input  logic [NumAgents-1:0] done_i,
    input  logic [NumAgents-1:0] ack_i,
    input  logic                 cmpl_i,
    output logic [NumAgents-1:0] grant_o,
    output logic                 doorbell_o,
    output logic [NumAgents-1:0] irq_o,
    output logic                 err_o,
    output logic                 busy_o
);
    localparam int IW = $clog2(NumAgents);
    localparam int CW = $clog2(TimeoutCycles);
    sched_state_e         state_q;
    logic [IW-1:0]        prio_q, owner_q, pick_idx;
    logic [CW-1:0]        cnt_q, cnt_inc;
    logic [NumAgents-1:0] pick_gnt;
    logic                 pick_valid, owner_done, owner_req, owner_ack, timeout;
    scmi_rr_picker #(.NumAgents(NumAgents)) u_picker (
        .req_i   (req_i),
        .ptr_i   (prio_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NumAgents; i++)
            if (pick_gnt[i]) pick_idx = IW'(i);
    end
    // grant_o is the registered one-hot owner, so masking with it filters non-owner pulses
    assign owner_done = |(done_i & grant_o);
    assign owner_req  = |(req_i & grant_o);
    assign owner_ack  = |(ack_i & grant_o);
    assign cnt_inc    = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign timeout    = cnt_inc == CW'(TimeoutCycles - 1);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prio_q     <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            grant_o    <= '0;
            doorbell_o <= 1'b0;
            irq_o      <= '0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            doorbell_o <= 1'b0;
            case (state_q)
                IDLE: if (pick_valid) begin
                    state_q <= GRANT;
                    grant_o <= pick_gnt;
                    owner_q <= pick_idx;
                    busy_o  <= 1'b1;
                end
                GRANT: if (owner_done) begin
                    state_q    <= DOORBELL;
                    doorbell_o <= 1'b1;
                end else if (!owner_req) begin
                    state_q <= IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                end
                DOORBELL: begin
                    state_q <= WAIT_CMPL;
                    cnt_q   <= '0;
                end
                WAIT_CMPL: begin
                    cnt_q <= cnt_inc;
                    if (cmpl_i || timeout) begin
                        state_q <= NOTIFY;
                        irq_o   <= grant_o;
                        err_o   <= !cmpl_i;
                    end
                end
                NOTIFY: if (owner_ack) begin
                    state_q <= IDLE;
                    grant_o <= '0;
                    irq_o   <= '0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    prio_q  <= owner_q == IW'(NumAgents - 1) ? '0 : owner_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scmi_channel_scheduler.sv
// tb_scmi_channel_scheduler: randomized transactions checked by an event scoreboard against a round-robin model
module tb_scmi_channel_scheduler;
    localparam int N = 4;
    localparam int T = 16;
    localparam int K_GNT = 0, K_DB = 1, K_IRQ = 2, K_REL = 3;
    typedef struct {
        int           kind;
        logic [N-1:0] val;
        logic         err;
        int           cyc;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req, done, ack, grant, irq;
    logic cmpl, doorbell, err, busy;
    ev_t exp_q[$];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int prio_m = 0;
    bit arm = 1'b0;
    logic [N-1:0] prev_g = '0;
    logic [N-1:0] prev_irq = '0;
    scmi_channel_scheduler #(.NumAgents(N), .TimeoutCycles(T)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .done_i     (done),
        .ack_i      (ack),
        .cmpl_i     (cmpl),
        .grant_o    (grant),
        .doorbell_o (doorbell),
        .irq_o      (irq),
        .err_o      (err),
        .busy_o     (busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic push(input int kind, input logic [N-1:0] val, input logic e, input int c);
        ev_t x;
        x = '{kind, val, e, c};
        exp_q.push_back(x);
    endtask
    task automatic check_ev(input int kind, input logic [N-1:0] val, input logic e);
        ev_t x;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: unexpected kind=%0d val=%b err=%b at cycle %0d", kind, val, e, cyc);
        end else begin
            x = exp_q.pop_front();
            if (x.kind != kind || x.val != val || x.err != e || x.cyc != cyc) begin
                miscompares++;
                $display("FAIL event: got kind=%0d val=%b err=%b cyc=%0d, want kind=%0d val=%b err=%b cyc=%0d",
                         kind, val, e, cyc, x.kind, x.val, x.err, x.cyc);
            end
        end
    endtask
    task automatic check_idle(input string name);
        vectors++;
        if ({grant, irq, doorbell, err, busy} != '0) begin
            miscompares++;
            $display("FAIL %s: grant=%b irq=%b doorbell=%b err=%b busy=%b, want all 0", name, grant, irq, doorbell, err, busy);
        end
    endtask
    always @(negedge clk) begin
        if (arm) begin
            if (grant != prev_g) begin
                if (prev_g == '0) begin
                    check_ev(K_GNT, grant, 1'b0);
                    vectors++;
                    if (!busy) begin
                        miscompares++;
                        $display("FAIL busy_on_grant: busy=%b want 1", busy);
                    end
                end else if (grant == '0) begin
                    check_ev(K_REL, '0, 1'b0);
                    check_idle("release_outputs");
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL grant_stable: grant changed %b -> %b, want unchanged", prev_g, grant);
                end
            end
            if (doorbell) check_ev(K_DB, '0, 1'b0);
            if (irq != '0 && prev_irq == '0) check_ev(K_IRQ, irq, err);
        end
        prev_g   <= grant;
        prev_irq <= irq;
    end
    task automatic step;
        @(posedge clk);
        #1;
        done = '0;
        ack  = '0;
        cmpl = 1'b0;
    endtask
    function automatic int winner(input logic [N-1:0] m);
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) begin
            s = m >> ((prio_m + i) % N);
            if (s[0]) return (prio_m + i) % N;
        end
        return 0;
    endfunction
    function automatic logic [N-1:0] others(input logic [N-1:0] oh);
        return N'($urandom_range(0, (1 << N) - 1)) & ~oh;
    endfunction
    // mode 0: full transaction, 1: abandon in GRANT, 2: reset during WAIT_CMPL; kf<0 picks a random completion delay
    task automatic run_txn(input logic [N-1:0] mask, input int mode, input int kf);
        int w, k, e;
        logic [N-1:0] oh;
        w  = winner(mask);
        oh = N'(1) << w;
        k  = kf < 0 ? int'($urandom_range(0, 20)) : kf;
        req = mask;
        push(K_GNT, oh, 1'b0, cyc + 1);
        step;
        repeat ($urandom_range(0, 2)) begin
            done = others(oh);
            ack  = others(oh);
            cmpl = 1'($urandom_range(0, 1));
            step;
        end
        if (mode == 1) begin
            req = '0;
            push(K_REL, '0, 1'b0, cyc + 1);
            step;
            step;
            return;
        end
        done = oh;
        push(K_DB, '0, 1'b0, cyc + 1);
        step;
        step;
        e = cyc;
        if (mode == 2) begin
            repeat (3) step;
            push(K_REL, '0, 1'b0, cyc);
            rst_n = 1'b0;
            req   = '0;
            @(negedge clk);
            check_idle("reset_mid_txn");
            step;
            rst_n  = 1'b1;
            prio_m = 0;
            step;
            return;
        end
        if (k <= T - 2) push(K_IRQ, oh, 1'b0, e + k + 1);
        else push(K_IRQ, oh, 1'b1, e + T - 1);
        repeat (k) begin
            done = others(oh);
            ack  = others(oh);
            step;
        end
        cmpl = 1'b1;
        step;
        repeat ($urandom_range(0, 3)) begin
            done = others(oh);
            ack  = others(oh);
            cmpl = 1'($urandom_range(0, 1));
            step;
        end
        ack = oh;
        req = '0;
        push(K_REL, '0, 1'b0, cyc + 1);
        prio_m = (w + 1) % N;
        step;
        step;
    endtask
    initial begin
        req  = '0;
        done = '0;
        ack  = '0;
        cmpl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst_n = 1'b1;
        arm   = 1'b1;
        step;
        repeat (5) run_txn(4'b1111, 0, -1);
        run_txn(4'b0001, 0, 5);
        run_txn(4'b1000, 0, 20);
        run_txn(4'b0010, 0, T - 2);
        run_txn(4'b0010, 0, T - 1);
        run_txn(4'b0010, 1, -1);
        run_txn(4'b0100, 2, -1);
        run_txn(4'b1111, 0, -1);
        for (int i = 0; i < 40; i++)
            run_txn(N'($urandom_range(1, (1 << N) - 1)),
                    $urandom_range(0, 19) == 0 ? 2 : ($urandom_range(0, 4) == 0 ? 1 : 0), -1);
        repeat (5) step;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/scmi_channel_scheduler.md
SCMI_CHANNEL_SCHEDULER -- requirements
Module: scmi_channel_scheduler

Interface
REQ-001 Parameter NumAgents, default 4: number of requesting agents sharing one SCMI mailbox channel; legal range 2..16.
REQ-002 Parameter TimeoutCycles, default 1024: maximum cycles spent in WAIT_CMPL before the scheduler aborts; legal range 2..65535.
REQ-003 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  NumAgents  level request for channel ownership, one bit per agent.
REQ-006 done_i  input  NumAgents  one-cycle pulse: the agent has finished writing the shared-memory payload.
REQ-007 ack_i  input  NumAgents  one-cycle pulse: the agent has consumed its completion notification.
REQ-008 cmpl_i  input  1  completion indication from the platform side, normally the mailbox completion-interrupt bit.
REQ-009 grant_o  output  NumAgents  one-hot or zero; identifies the current channel owner.
REQ-010 doorbell_o  output  1  one-cycle pulse that rings the platform doorbell.
REQ-011 irq_o  output  NumAgents  level completion interrupt to the owner.
REQ-012 err_o  output  1  high together with irq_o when the transaction timed out.
REQ-013 busy_o  output  1  high in every state except IDLE.

Function
REQ-014 The FSM shall have exactly the states IDLE, GRANT, DOORBELL, WAIT_CMPL and NOTIFY.
REQ-015 IDLE: when any req_i bit is set, the scheduler picks an agent round-robin, starting from pointer prio_q; grant_o becomes one-hot on the next cycle (1-cycle latency) and the state moves to GRANT.
REQ-016 GRANT: done_i[owner] moves the state to DOORBELL; if req_i[owner] drops without done_i, the state returns to IDLE, grant_o clears and no doorbell is issued.
REQ-017 DOORBELL: doorbell_o is high for exactly this one cycle; the timeout counter is cleared; the next state is WAIT_CMPL.
REQ-018 WAIT_CMPL: cmpl_i moves the state to NOTIFY with err cleared; otherwise the counter increments, and when it reaches TimeoutCycles-1 the state moves to NOTIFY with err set.
REQ-019 If cmpl_i and the timeout terminal count occur in the same cycle, the completion wins and err_o stays 0.
REQ-020 NOTIFY: irq_o[owner] is held high, with err_o valid, until ack_i[owner]; on that ack the state returns to IDLE the next cycle, grant_o, irq_o and err_o clear, and prio_q becomes owner+1 modulo NumAgents.
REQ-021 done_i, ack_i or cmpl_i outside their consuming state, or done_i/ack_i from a non-owner, shall be ignored with no side effects.
REQ-022 grant_o shall remain stable from GRANT through NOTIFY; the owner shall never change mid-transaction.
REQ-023 The timeout counter shall be $clog2(TimeoutCycles) bits wide and shall saturate rather than wrap.
REQ-024 The grant-to-grant fairness bound shall be NumAgents-1 intervening transactions per agent.

Reset
REQ-025 While rst_ni is low: state=IDLE, prio_q=0, counter=0, err=0, and grant_o, doorbell_o, irq_o, err_o and busy_o are all 0.
REQ-026 Reset asserted mid-transaction shall abort immediately with no pending doorbell, irq or error retained.

Structure
REQ-027 Package scmi_sched_pkg shall hold the state enum sched_state_e and the default constants.
REQ-028 Round-robin selection shall be the sub-module scmi_rr_picker: inputs are the request vector and the pointer; outputs are a one-hot grant and a valid flag; it is purely combinational.
REQ-029 All outputs shall be registered, except the picker's internal result.

Verification
REQ-030 Basic transaction: req_i=0001, done_i[0] pulsed, cmpl_i pulsed 5 cycles later, ack_i[0] pulsed -> grant_o=0001 one cycle after req, doorbell_o one pulse, irq_o[0]=1 and err_o=0 until ack, then busy_o=0.
REQ-031 Fairness: req_i=1111 held, with every transaction completed -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-032 Timeout: TimeoutCycles=16 and cmpl_i never asserted -> irq_o[owner]=1 and err_o=1 exactly 15 cycles after WAIT_CMPL entry.
REQ-033 Simultaneous events: cmpl_i in the terminal-count cycle -> err_o=0; spurious done_i[2] and ack_i[3] while agent 1 owns the channel -> no state change.
REQ-034 Abandon and reset: req_i[1] dropped in GRANT -> IDLE with no doorbell; rst_ni pulsed in WAIT_CMPL -> all outputs 0 and the next grant goes to agent 0.
